fp_norm_pipe: RTL and testbench

Parametrised, pipelined post-addition normaliser for the FPU add/sub datapath. It takes the raw unsigned magnitude sum and the pre-normalisation exponent. It performs a full leading-zero count and left shift, so the result is not limited to a 0/1-position correction. It outputs a normalised mantissa, the adjusted exponent, guard/round/sticky bits and status flags to the rounding stage. Two register stages with valid/ready flow control sit between the adder and the rounder.

---
 rtl/fp_norm_pipe.sv | 191 +++++++++++++++++++
 tb/tb_fp_norm_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe -- two-stage post-addition normaliser for the FPU add/sub path.
//
// Takes the unsigned magnitude sum from the adder and the pre-normalisation
// exponent. It counts the leading zeros, left-shifts the sum to bring the
// leading one into the hidden-bit position, and adjusts the exponent to match.
// It hands mantissa, exponent, guard/round/sticky and status flags to the
// rounder.
//
// Build option:
//   FPU_NORM_DENORM_CLAMP_EN  when defined, the shift is clamped to exp_in, so
//                             an underflowing result comes out as a denormal
//                             with exp_out=0. When undefined, the mantissa is
//                             always fully normalised, and exp_out saturates
//                             at 0 on underflow.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready depends combinationally on out_ready
//   sum_in, exp_in  raw magnitude sum and its exponent
//   out_valid/ready output handshake
//   mant_out        normalised mantissa (MSB = hidden bit)
//   exp_out         adjusted exponent
//   grs_out         {guard, round, sticky}
//   shift_out       left-shift amount applied
//   zero_out        input sum was zero
//   underflow_out   leading-zero count exceeded exp_in
module fp_norm_pipe #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int SUM_W  = MANT_W + 3,
  parameter int LZC_W  = $clog2(SUM_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [2:0]        grs_out,
  output logic [LZC_W-1:0]  shift_out,
  output logic              zero_out,
  output logic              underflow_out
);

  // Shift count and exponent are compared and subtracted at a common width.
  // The extra bit keeps the comparison unsigned, with no truncation.
  localparam int CMP_W = ((LZC_W > EXP_W) ? LZC_W : EXP_W) + 1;
  // Number of bits below guard and round that fold into sticky.
  localparam int STK_W = SUM_W - MANT_W - 2;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  expo;
    logic [2:0]        grs;
    logic [LZC_W-1:0]  shift;
    logic              zero;
    logic              unf;
  } norm_res_t;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_load, s1_load;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  // While reset is held, no beat may be accepted.
  assign in_ready = s1_load && !rst;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the operands and the leading-zero count
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] s1_sum_q,  s1_sum_d;
  logic [EXP_W-1:0] s1_exp_q,  s1_exp_d;
  logic [LZC_W-1:0] s1_lzc_q,  s1_lzc_d;
  logic             s1_zero_q, s1_zero_d;
  logic [LZC_W-1:0] lzc;

  // The scan runs from LSB to MSB, so the highest set bit is the last
  // assignment and wins. An all-zero sum keeps the default of SUM_W.
  always_comb begin
    lzc = LZC_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (sum_in[i]) lzc = LZC_W'(SUM_W - 1 - i);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_exp_d   = s1_exp_q;
    s1_lzc_d   = s1_lzc_q;
    s1_zero_d  = s1_zero_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d  = sum_in;
        s1_exp_d  = exp_in;
        s1_lzc_d  = lzc;
        s1_zero_d = (sum_in == '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift, exponent adjust, GRS extraction
  // ---------------------------------------------------------------------------
  logic [CMP_W-1:0] lzc_x, exp_x;
  logic             unf;
  logic [LZC_W-1:0] sh;
  logic [EXP_W-1:0] exp_adj;
  logic [SUM_W-1:0] shifted;
  norm_res_t        res;
  norm_res_t        res_q, res_d;

  always_comb begin
    lzc_x = CMP_W'(s1_lzc_q);
    exp_x = CMP_W'(s1_exp_q);
    unf   = (lzc_x > exp_x);
`ifdef FPU_NORM_DENORM_CLAMP_EN
    // On underflow exp_in < lzc <= SUM_W, so exp_in fits in the shift width.
    sh      = unf ? LZC_W'(s1_exp_q) : s1_lzc_q;
    exp_adj = EXP_W'(exp_x - CMP_W'(sh));
`else
    sh      = s1_lzc_q;
    exp_adj = unf ? '0 : EXP_W'(exp_x - lzc_x);
`endif
    shifted = s1_sum_q << sh;

    res       = '0;
    res.mant  = shifted[SUM_W-1 -: MANT_W];
    res.grs   = {shifted[SUM_W-MANT_W-1], shifted[SUM_W-MANT_W-2],
                 |shifted[STK_W-1:0]};
    res.expo  = exp_adj;
    res.shift = sh;
    res.unf   = unf;
    // A zero sum would otherwise report a full-width shift and an underflow.
    if (s1_zero_q) begin
      res      = '0;
      res.zero = 1'b1;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      // When a bubble moves in, the old result is kept to avoid needless toggling.
      if (s1_valid_q) res_d = res;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_exp_q   <= '0;
      s1_lzc_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_exp_q   <= s1_exp_d;
      s1_lzc_q   <= s1_lzc_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign mant_out      = res_q.mant;
  assign exp_out       = res_q.expo;
  assign grs_out       = res_q.grs;
  assign shift_out     = res_q.shift;
  assign zero_out      = res_q.zero;
  assign underflow_out = res_q.unf;

endmodule

// File: tb/tb_fp_norm_pipe.sv
module tb_fp_norm_pipe;
  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int SUM_W  = 27;
  localparam int LZC_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SUM_W-1:0]  sum_in = '0;
  logic [EXP_W-1:0]  exp_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [MANT_W-1:0] mant_out;
  logic [EXP_W-1:0]  exp_out;
  logic [2:0]        grs_out;
  logic [LZC_W-1:0]  shift_out;
  logic              zero_out;
  logic              underflow_out;

  fp_norm_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .exp_out(exp_out), .grs_out(grs_out),
    .shift_out(shift_out), .zero_out(zero_out), .underflow_out(underflow_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  e;
    logic [2:0]        grs;
    logic [LZC_W-1:0]  sh;
    logic              zero;
    logic              unf;
  } res_t;

  int   vectors = 0;
  int   miscompares = 0;
  res_t exp_q[$];

  function automatic res_t mk(logic [MANT_W-1:0] m, logic [EXP_W-1:0] e,
                              logic [2:0] g, logic [LZC_W-1:0] s, logic z, logic u);
    res_t r;
    r.mant = m; r.e = e; r.grs = g; r.sh = s; r.zero = z; r.unf = u;
    return r;
  endfunction

  // Reference: the sum is doubled until its top bit is set; the number of
  // doublings is the leading-zero count. The result is read from the scaled
  // integer.
  function automatic res_t model(logic [SUM_W-1:0] s, logic [EXP_W-1:0] e);
    res_t   r;
    longint v;
    int     lzc, sh;
    r = '0;
    if (s == 0) begin
      r.zero = 1'b1;
      return r;
    end
    v = longint'(s);
    lzc = 0;
    while (v < (longint'(1) << (SUM_W - 1))) begin
      v = v * 2;
      lzc++;
    end
`ifdef FPU_NORM_DENORM_CLAMP_EN
    sh = (lzc > int'(e)) ? int'(e) : lzc;
`else
    sh = lzc;
`endif
    v = (longint'(s) * (longint'(1) << sh)) % (longint'(1) << SUM_W);
    r.mant = MANT_W'(v / 8);
    r.grs  = 3'(v % 8);           // sticky source is a single bit here
    r.sh   = LZC_W'(sh);
    r.unf  = (lzc > int'(e));
`ifdef FPU_NORM_DENORM_CLAMP_EN
    r.e = EXP_W'(int'(e) - sh);
`else
    r.e = r.unf ? '0 : EXP_W'(int'(e) - lzc);
`endif
    return r;
  endfunction

  function automatic res_t dut_res();
    return mk(mant_out, exp_out, grs_out, shift_out, zero_out, underflow_out);
  endfunction

  task automatic check(string name, res_t got, res_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got mant=%h exp=%0d grs=%b sh=%0d z=%b u=%b, want mant=%h exp=%0d grs=%b sh=%0d z=%b u=%b",
               name, got.mant, got.e, got.grs, got.sh, got.zero, got.unf,
               want.mant, want.e, want.grs, want.sh, want.zero, want.unf);
    end
  endtask

  task automatic check_bit(string name, logic got, logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  // Compare process: sampled on the falling edge. The inputs were driven just
  // after the rising edge, so each handshake seen here commits on the next rising edge.
  res_t held;
  logic hold_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check_bit("hold_valid", out_valid, 1'b1);
        check("hold_data", dut_res(), held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got a beat, want none");
        end else begin
          check("stream", dut_res(), exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(sum_in, exp_in));
      hold_prev = out_valid && !out_ready;
      held      = dut_res();
    end
  end

  // Sends one beat into an empty pipe and checks the exact latency and the result.
  task automatic send_one(string name, logic [SUM_W-1:0] s, logic [EXP_W-1:0] e, res_t want);
    @(posedge clk); #1;
    in_valid = 1'b1; sum_in = s; exp_in = e; out_ready = 1'b1;
    @(negedge clk);
    check_bit({name, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit({name, "_early"}, out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_bit({name, "_valid"}, out_valid, 1'b1);
    check(name, dut_res(), want);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  res_t r_a, r_b, r_c;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check("reset_outputs", dut_res(), '0);

    // Pin the reference model to hand-computed values
    check("model_lit1", model(27'h4000007, 8'd100), mk(24'h800000, 8'd100, 3'b111, 5'd0, 1'b0, 1'b0));
    check("model_lit2", model(27'h0000001, 8'd100), mk(24'h800000, 8'd74, 3'b000, 5'd26, 1'b0, 1'b0));
    check("model_lit3", model(27'h0000000, 8'd50), mk(24'h0, 8'd0, 3'b000, 5'd0, 1'b1, 1'b0));
`ifdef FPU_NORM_DENORM_CLAMP_EN
    check("model_lit4", model(27'h0000100, 8'd5), mk(24'h000400, 8'd0, 3'b000, 5'd5, 1'b0, 1'b1));
`else
    check("model_lit4", model(27'h0000100, 8'd5), mk(24'h800000, 8'd0, 3'b000, 5'd18, 1'b0, 1'b1));
`endif

    // Directed beats with literal expectations
    send_one("dir_grs", 27'h4000007, 8'd100, mk(24'h800000, 8'd100, 3'b111, 5'd0, 1'b0, 1'b0));
    send_one("dir_lsb", 27'h0000001, 8'd100, mk(24'h800000, 8'd74, 3'b000, 5'd26, 1'b0, 1'b0));
    send_one("dir_zero", 27'h0000000, 8'd50, mk(24'h0, 8'd0, 3'b000, 5'd0, 1'b1, 1'b0));
`ifdef FPU_NORM_DENORM_CLAMP_EN
    send_one("dir_unf", 27'h0000100, 8'd5, mk(24'h000400, 8'd0, 3'b000, 5'd5, 1'b0, 1'b1));
`else
    send_one("dir_unf", 27'h0000100, 8'd5, mk(24'h800000, 8'd0, 3'b000, 5'd18, 1'b0, 1'b1));
`endif
    send_one("dir_exact", 27'h0000800, 8'd15, model(27'h0000800, 8'd15));

    // Backpressure: A and B fill the pipe, and C is refused until out_ready rises.
    r_a = model(27'h1234567, 8'd40);
    r_b = model(27'h0000ABC, 8'd200);
    r_c = model(27'h7FFFFFF, 8'd1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; sum_in = 27'h1234567; exp_in = 8'd40;
    @(negedge clk); check_bit("bp_accept_a", in_ready, 1'b1);
    @(posedge clk); #1;
    sum_in = 27'h0000ABC; exp_in = 8'd200;
    @(negedge clk); check_bit("bp_accept_b", in_ready, 1'b1);
    @(posedge clk); #1;
    sum_in = 27'h7FFFFFF; exp_in = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("bp_block_c", in_ready, 1'b0);
      check("bp_frozen_a", dut_res(), r_a);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("bp_release_in_ready", in_ready, 1'b1);
    check_bit("bp_out_a_valid", out_valid, 1'b1);
    check("bp_out_a", dut_res(), r_a);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("bp_out_b_valid", out_valid, 1'b1);
    check("bp_out_b", dut_res(), r_b);
    @(posedge clk);
    @(negedge clk);
    check_bit("bp_out_c_valid", out_valid, 1'b1);
    check("bp_out_c", dut_res(), r_c);
    @(posedge clk);
    @(negedge clk);
    check_bit("bp_drained", out_valid, 1'b0);

    // Reset while two beats are in flight; the beat offered during reset is dropped.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; sum_in = 27'h0300000; exp_in = 8'd90;
    @(posedge clk); #1;
    sum_in = 27'h0000033; exp_in = 8'd60;
    @(posedge clk); #1;
    sum_in = 27'h0001000; exp_in = 8'd70;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    check("midrst_outputs", dut_res(), '0);
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("midrst_no_ghost", out_valid, 1'b0);
    send_one("post_rst", 27'h0000001, 8'd100, mk(24'h800000, 8'd74, 3'b000, 5'd26, 1'b0, 1'b0));

    // Random traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       sum_in = '0;
        1:       sum_in = SUM_W'($urandom_range(1, 255));
        default: sum_in = SUM_W'($urandom) >> $urandom_range(0, SUM_W - 1);
      endcase
      exp_in = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom_range(0, 7))
                                           : EXP_W'($urandom_range(0, 255));
    end

    // Drain, with a bounded wait
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d beats outstanding, want 0", exp_q.size());
    end
    check_bit("final_idle", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
